expu_accumulator: RTL and testbench
===================================

EXPU_ACCUMULATOR -- requirements
Module: expu_accumulator

Interface
REQ-001 SHALL have parameter FPFORMAT, default FPFORMAT_IN, format of the exponential values received.
REQ-002 SHALL have parameter ACC_WIDTH, default EXPU_ACC_WIDTH (32), accumulator width in bits.
REQ-003 SHALL have parameter ACC_FRAC_BITS, default EXPU_ACC_FRAC_BITS (16), fraction bits of the fixed-point accumulator.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, element-counter width.
REQ-005 SHALL have ports (clock and reset first): clk_i in 1 clock; rst_ni in 1 reset; clear_i in 1 sync clear; in_valid_i in 1; in_ready_o out 1; in_data_i in fp_width(FPFORMAT) exponent value from the exponential row; in_last_i in 1 last element of row; sum_valid_o out 1; sum_ready_i in 1; sum_o out ACC_WIDTH row sum; count_o out CNT_WIDTH elements in row; err_o out 1 invalid input seen; ovf_o out 1 overflow seen.
REQ-006 SHALL use reset rst_ni, asynchronous, active-low; clock clk_i.

Function
REQ-007 SHALL accept an element when in_valid_i && in_ready_o on a rising clk_i edge.
REQ-008 SHALL convert each accepted element to unsigned fixed point (ACC_FRAC_BITS fraction bits): (1.mant) shifted by (exp - bias); right shifts truncate.
REQ-009 SHALL convert zero/denormal exponent to 0; sign=1, or exponent all-ones (Inf/NaN), to 0 with err_o set.
REQ-010 SHALL register the converted value (stage 1), then add it to the accumulator (stage 2).
REQ-011 SHALL implement FSM IDLE, ACC, DRAIN, DONE; in_ready_o = 1 only in IDLE and ACC.
REQ-012 SHALL transition: IDLE->ACC on accept without last; IDLE or ACC->DRAIN on accept with in_last_i; DRAIN->DONE after one cycle; DONE->IDLE on sum_valid_o && sum_ready_i.
REQ-013 SHALL assert sum_valid_o only in DONE, with sum_o and count_o stable until the handshake; last accepted in cycle N gives sum_valid_o in cycle N+2.
REQ-014 SHALL zero accumulator, count, err_o and ovf_o on the DONE->IDLE handshake so the next row starts clean.
REQ-015 SHALL increment count_o per accepted element, saturating at all-ones.
REQ-016 SHALL, on clear_i, go to IDLE next cycle, discard the pipeline stage, and zero all state; clear_i wins over simultaneous accept or handshake.
REQ-017 SHALL hold err_o and ovf_o sticky from first occurrence until the DONE->IDLE handshake or clear_i.

Reset
REQ-018 SHALL, on rst_ni low, immediately set state IDLE and in_ready_o=1, sum_valid_o=0, sum_o=0, count_o=0, err_o=0, ovf_o=0, stage-1 register=0.
REQ-019 SHALL, on reset mid-row, discard partial sum and count with no residual effect.

Configuration
REQ-020 SHALL compile saturation only when macro SFM_ACC_SATURATE_EN is defined.
REQ-021 With SFM_ACC_SATURATE_EN, conversion and accumulation SHALL clamp to all-ones on overflow and set ovf_o.
REQ-022 Without SFM_ACC_SATURATE_EN, conversion and accumulation SHALL wrap modulo 2^ACC_WIDTH and ovf_o SHALL be tied 0.

Structure
REQ-023 SHALL take EXPU_ACC_WIDTH, EXPU_ACC_FRAC_BITS and enum acc_state_e (IDLE, ACC, DRAIN, DONE) from sfm_pkg.
REQ-024 SHALL place the float-to-fixed conversion in combinational sub-module expu_fp2fix.

Verification (BF16, ACC_WIDTH=32, ACC_FRAC_BITS=16)
REQ-025 SHALL check: row 0x3F80, 0x3F00, 0x3F00 (last), sum_ready_i=1 -> sum_o=0x00020000, count_o=3, sum_valid_o two cycles after last.
REQ-026 SHALL check: single element 0x3F80 with last in IDLE -> sum_o=0x00010000, count_o=1, err_o=0.
REQ-027 SHALL check: row 0xBF80, 0x7FC0 (last) -> sum_o=0, count_o=2, err_o=1, cleared after handshake.
REQ-028 SHALL check: 0x4700, 0x4700 (last) -> with macro sum_o=0xFFFFFFFF, ovf_o=1; without macro sum_o=0x00000000, ovf_o=0.
REQ-029 SHALL check: sum_ready_i low 5 cycles in DONE -> sum_o/count_o held, in_ready_o=0; new row accepted the cycle after the handshake.
REQ-030 SHALL check: clear_i (and separately rst_ni) after 2 of 4 elements -> IDLE, all outputs 0, next row 0x3F80 (last) sums to 0x00010000.

Source files
------------

// File: rtl/sfm_pkg.sv
// Shared types and constants for the softmax exponential-unit blocks:
// floating-point format descriptors, accumulator geometry and accumulator FSM states.
package sfm_pkg;

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP16 = 2'd1,
        BF16 = 2'd2
    } fp_format_e;

    localparam fp_format_e FPFORMAT_IN = BF16;

    localparam int unsigned EXPU_ACC_WIDTH     = 32;
    localparam int unsigned EXPU_ACC_FRAC_BITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } acc_state_e;

    function automatic int unsigned fp_exp_bits(input fp_format_e fmt);
        case (fmt)
            FP32:    return 8;
            FP16:    return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned fp_man_bits(input fp_format_e fmt);
        case (fmt)
            FP32:    return 23;
            FP16:    return 10;
            default: return 7;
        endcase
    endfunction

    function automatic int unsigned fp_width(input fp_format_e fmt);
        return 1 + fp_exp_bits(fmt) + fp_man_bits(fmt);
    endfunction

endpackage

// File: rtl/expu_fp2fix.sv
// Combinational float -> unsigned fixed-point conversion of one exponential value.
// SFM_ACC_SATURATE_EN: clamp to all-ones on overflow and report it; otherwise wrap.
module expu_fp2fix
    import sfm_pkg::*;
#(
    parameter fp_format_e  FPFORMAT      = FPFORMAT_IN,
    parameter int unsigned ACC_WIDTH     = EXPU_ACC_WIDTH,
    parameter int unsigned ACC_FRAC_BITS = EXPU_ACC_FRAC_BITS
) (
    input  logic [fp_width(FPFORMAT)-1:0] fp_i,
    output logic [ACC_WIDTH-1:0]          fix_o,
    output logic                          err_o,
    output logic                          ovf_o
);

    localparam int unsigned EB   = fp_exp_bits(FPFORMAT);
    localparam int unsigned MB   = fp_man_bits(FPFORMAT);
    localparam int unsigned BIAS = (1 << (EB - 1)) - 1;
    // Net left shift applied to the integer significand {1,mant}.
    localparam int          OFFS = int'(ACC_FRAC_BITS) - int'(MB) - int'(BIAS);
`ifdef SFM_ACC_SATURATE_EN
    localparam int unsigned WW   = ACC_WIDTH + MB + 1;
`else
    localparam int unsigned WW   = ACC_WIDTH;
`endif

    logic          sign_bit;
    logic [EB-1:0] exp_f;
    logic [MB:0]   sig;
    logic [WW-1:0] wide;
    logic          conv_ovf;
    int            sh_amt;

    assign sign_bit = fp_i[EB+MB];
    assign exp_f    = fp_i[EB+MB-1:MB];
    assign sig      = {1'b1, fp_i[MB-1:0]};

    always_comb begin
        wide     = '0;
        conv_ovf = 1'b0;
        err_o    = 1'b0;
        sh_amt   = int'(exp_f) + OFFS;
        if (sign_bit || (exp_f == '1)) begin
            err_o = 1'b1;
        end else if (exp_f != '0) begin
            if (sh_amt >= 0) begin
                wide = WW'(sig) << sh_amt;
`ifdef SFM_ACC_SATURATE_EN
                conv_ovf = (sh_amt >= int'(ACC_WIDTH)) || (|wide[WW-1:ACC_WIDTH]);
`endif
            end else begin
                wide = WW'(sig) >> (-sh_amt);
            end
        end
    end

`ifdef SFM_ACC_SATURATE_EN
    assign fix_o = conv_ovf ? '1 : wide[ACC_WIDTH-1:0];
    assign ovf_o = conv_ovf;
`else
    assign fix_o = wide[ACC_WIDTH-1:0];
    assign ovf_o = conv_ovf;
`endif

endmodule

// File: rtl/expu_accumulator.sv
// Sums one row of exponential values into a fixed-point accumulator (convert, register, add).
// SFM_ACC_SATURATE_EN: saturating conversion/accumulation with sticky ovf_o; otherwise wrap, ovf_o=0.
module expu_accumulator
    import sfm_pkg::*;
#(
    parameter fp_format_e  FPFORMAT      = FPFORMAT_IN,
    parameter int unsigned ACC_WIDTH     = EXPU_ACC_WIDTH,
    parameter int unsigned ACC_FRAC_BITS = EXPU_ACC_FRAC_BITS,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [fp_width(FPFORMAT)-1:0] in_data_i,
    input  logic                          in_last_i,
    output logic                          sum_valid_o,
    input  logic                          sum_ready_i,
    output logic [ACC_WIDTH-1:0]          sum_o,
    output logic [CNT_WIDTH-1:0]          count_o,
    output logic                          err_o,
    output logic                          ovf_o
);

    acc_state_e            state_q, state_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [ACC_WIDTH-1:0]  s1_data_q, s1_data_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0]  conv_fix;
    logic                  conv_err;
    logic                  conv_ovf;
    logic                  accept;
    logic                  handshake;
`ifdef SFM_ACC_SATURATE_EN
    logic [ACC_WIDTH:0]    add_full;
`endif

    expu_fp2fix #(
        .FPFORMAT      (FPFORMAT),
        .ACC_WIDTH     (ACC_WIDTH),
        .ACC_FRAC_BITS (ACC_FRAC_BITS)
    ) u_fp2fix (
        .fp_i  (in_data_i),
        .fix_o (conv_fix),
        .err_o (conv_err),
        .ovf_o (conv_ovf)
    );

    assign in_ready_o  = (state_q == IDLE) || (state_q == ACC);
    assign sum_valid_o = (state_q == DONE);
    assign accept      = in_valid_i && in_ready_o;
    assign handshake   = sum_valid_o && sum_ready_i;

    assign sum_o   = acc_q;
    assign count_o = cnt_q;
    assign err_o   = err_q;
    assign ovf_o   = ovf_q;

    always_comb begin
        state_d    = state_q;
        s1_valid_d = accept;
        s1_data_d  = accept ? conv_fix : '0;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ovf_d      = ovf_q;

        if (s1_valid_q) begin
`ifdef SFM_ACC_SATURATE_EN
            add_full = {1'b0, acc_q} + {1'b0, s1_data_q};
            acc_d    = add_full[ACC_WIDTH] ? '1 : add_full[ACC_WIDTH-1:0];
            ovf_d    = ovf_q | add_full[ACC_WIDTH];
`else
            acc_d    = acc_q + s1_data_q;
`endif
        end
`ifdef SFM_ACC_SATURATE_EN
        else begin
            add_full = '0;
        end
`endif

        if (accept) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            err_d = err_d | conv_err;
            ovf_d = ovf_d | conv_ovf;
        end

        case (state_q)
            IDLE, ACC: if (accept) state_d = in_last_i ? DRAIN : ACC;
            DRAIN:     state_d = DONE;
            DONE:      if (handshake) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // Result has been consumed: start the next row from a clean slate.
        if (handshake) begin
            acc_d = '0;
            cnt_d = '0;
            err_d = 1'b0;
            ovf_d = 1'b0;
        end

        if (clear_i) begin
            state_d    = IDLE;
            s1_valid_d = 1'b0;
            s1_data_d  = '0;
            acc_d      = '0;
            cnt_d      = '0;
            err_d      = 1'b0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_expu_accumulator.sv
// Scoreboard bench for expu_accumulator (BF16, 32-bit accumulator, 16 fraction bits):
// stimulus pushes expected row results, a negedge monitor pops them on each sum handshake.
module tb_expu_accumulator;
    import sfm_pkg::*;

    typedef struct {
        logic [31:0] sum;
        logic [15:0] cnt;
        logic        err;
        logic        ovf;
    } exp_t;

    logic        clk_i;
    logic        rst_ni;
    logic        clear_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_data_i;
    logic        in_last_i;
    logic        sum_valid_o;
    logic        sum_ready_i;
    logic [31:0] sum_o;
    logic [15:0] count_o;
    logic        err_o;
    logic        ovf_o;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    expu_accumulator #(
        .FPFORMAT      (BF16),
        .ACC_WIDTH     (32),
        .ACC_FRAC_BITS (16),
        .CNT_WIDTH     (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .sum_valid_o (sum_valid_o),
        .sum_ready_i (sum_ready_i),
        .sum_o       (sum_o),
        .count_o     (count_o),
        .err_o       (err_o),
        .ovf_o       (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every handshake pops one expected row result.
    always @(negedge clk_i) begin
        if (rst_ni && sum_valid_o && sum_ready_i) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: sum 0x%0h with empty scoreboard", sum_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("row_sum",   64'(sum_o),   64'(e.sum));
                chk("row_count", 64'(count_o), 64'(e.cnt));
                chk("row_err",   64'(err_o),   64'(e.err));
                chk("row_ovf",   64'(ovf_o),   64'(e.ovf));
                $display("row result: sum=0x%08h count=%0d err=%0d ovf=%0d", sum_o, count_o, err_o, ovf_o);
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] s, input logic [15:0] c, input logic e, input logic o);
        exp_t r;
        r.sum = s; r.cnt = c; r.err = e; r.ovf = o;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send(input logic [15:0] d, input logic l);
        int guard = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = l;
        while (!in_ready_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready_o stuck at %0d, want 1", in_ready_o);
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!sum_valid_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 50) begin
            total++;
            bad++;
            $display("FAIL done_timeout: sum_valid_o=%0d want 1", sum_valid_o);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"},     64'(in_ready_o),  64'd1);
        chk({tag, "_sum_valid"}, 64'(sum_valid_o), 64'd0);
        chk({tag, "_sum"},       64'(sum_o),       64'd0);
        chk({tag, "_count"},     64'(count_o),     64'd0);
        chk({tag, "_err"},       64'(err_o),       64'd0);
        chk({tag, "_ovf"},       64'(ovf_o),       64'd0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_last_i   = 1'b0;
        sum_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk_idle("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 1.0 + 0.5 + 0.5 = 2.0, result appears two cycles after the last.
        sb_q.push_back(mk(32'h0002_0000, 16'd3, 1'b0, 1'b0));
        send(16'h3F80, 1'b0);
        send(16'h3F00, 1'b0);
        send(16'h3F00, 1'b1);
        chk("latency_drain", 64'(sum_valid_o), 64'd0);
        @(negedge clk_i);
        chk("latency_done", 64'(sum_valid_o), 64'd1);
        @(negedge clk_i);

        // Single element with last straight from IDLE.
        sb_q.push_back(mk(32'h0001_0000, 16'd1, 1'b0, 1'b0));
        send(16'h3F80, 1'b1);
        wait_done();
        @(negedge clk_i);

        // Negative and NaN inputs contribute zero and flag an error.
        sb_q.push_back(mk(32'h0000_0000, 16'd2, 1'b1, 1'b0));
        send(16'hBF80, 1'b0);
        send(16'h7FC0, 1'b1);
        wait_done();
        @(negedge clk_i);
        chk("err_cleared", 64'(err_o), 64'd0);

        // 2^15 + 2^15 overflows a 32-bit Q16.16 accumulator.
`ifdef SFM_ACC_SATURATE_EN
        sb_q.push_back(mk(32'hFFFF_FFFF, 16'd2, 1'b0, 1'b1));
`else
        sb_q.push_back(mk(32'h0000_0000, 16'd2, 1'b0, 1'b0));
`endif
        send(16'h4700, 1'b0);
        send(16'h4700, 1'b1);
        wait_done();
        @(negedge clk_i);

        // Backpressure: result held for 5 cycles, then new row right after handshake.
        @(posedge clk_i);
        #1 sum_ready_i = 1'b0;
        @(negedge clk_i);
        sb_q.push_back(mk(32'h0001_8000, 16'd2, 1'b0, 1'b0));
        send(16'h3F80, 1'b0);
        send(16'h3F00, 1'b1);
        wait_done();
        for (int i = 0; i < 5; i++) begin
            chk("hold_sum",   64'(sum_o),      64'h0001_8000);
            chk("hold_count", 64'(count_o),    64'd2);
            chk("hold_ready", 64'(in_ready_o), 64'd0);
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1 sum_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("post_hs_ready", 64'(in_ready_o), 64'd1);
        sb_q.push_back(mk(32'h0001_0000, 16'd1, 1'b0, 1'b0));
        send(16'h3F80, 1'b1);
        wait_done();
        @(negedge clk_i);

        // clear_i after 2 of 4 elements discards the partial row.
        send(16'hBF80, 1'b0);
        send(16'h3F80, 1'b0);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk_idle("clear");
        sb_q.push_back(mk(32'h0001_0000, 16'd1, 1'b0, 1'b0));
        send(16'h3F80, 1'b1);
        wait_done();
        @(negedge clk_i);

        // Asynchronous reset mid-row.
        send(16'hBF80, 1'b0);
        send(16'h3F80, 1'b0);
        rst_ni = 1'b0;
        #1;
        chk_idle("async_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        sb_q.push_back(mk(32'h0001_0000, 16'd1, 1'b0, 1'b0));
        send(16'h3F80, 1'b1);
        wait_done();

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk_i);
        @(negedge clk_i);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d results outstanding, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
